mem_req_ctrl: RTL

//   Request front-end that sits directly upstream of the single-port memory block and drives its

---
 rtl/mem_req_ctrl_if.sv | 33 +++
 rtl/mem_req_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/mem_req_ctrl_if.sv
// Host request/response and memory-pin bundle for mem_req_ctrl.
// slave = controller side, master = host/memory side.
interface mem_req_ctrl_if #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic [AWIDTH-1:0] rsp_addr;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr,
           mem_addr, mem_wr_en, mem_rd_en, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr,
           mem_addr, mem_wr_en, mem_rd_en, mem_wdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Request front-end for the single-port memory: queues host requests in a FIFO,
// issues them one at a time and returns read data over a valid/ready channel.
package mem_pkg;
  typedef struct packed {
    int unsigned AWIDTH;
    int unsigned DWIDTH;
  } mem_param_t;

  localparam mem_param_t MEM_PARAM_DEFAULT = '{AWIDTH: 8, DWIDTH: 32};
endpackage

module mem_req_ctrl #(
  parameter mem_pkg::mem_param_t P     = mem_pkg::MEM_PARAM_DEFAULT,
  parameter int unsigned         DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_req_ctrl_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int unsigned AW = P.AWIDTH;
  localparam int unsigned DW = P.DWIDTH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  entry_t        fifo_mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  state_t        state, state_nxt;
  entry_t        head;
  logic          full, empty, push, pop, issue_rd;

  assign full          = (level == LW'(DEPTH));
  assign empty         = (level == '0);
  assign head          = fifo_mem[rptr];
  assign bus.req_ready = !rst && !full;
  assign push          = bus.req_valid && bus.req_ready;
  assign fifo_level    = level;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Issue only from IDLE: a pending read blocks all further issue until its
  // response handshake, so no write can disturb the memory's read register.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    issue_rd      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          bus.mem_addr  = head.addr;
          bus.mem_wdata = head.wdata;
          if (head.wr) begin
            bus.mem_wr_en = 1'b1;
          end else begin
            bus.mem_rd_en = 1'b1;
            issue_rd      = 1'b1;
            state_nxt     = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_nxt = RSP;
      RSP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.rsp_rdata <= '0;
      bus.rsp_addr  <= '0;
    end else begin
      state <= state_nxt;
      if (issue_rd)         bus.rsp_addr  <= head.addr;
      if (state == RD_WAIT) bus.rsp_rdata <= bus.mem_rdata;
    end
  end
endmodule
